// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered NZCV flags, condition codes evaluated
// at accept, an iterative shift-add MUL, and valid/ready on both sides.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wb,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags,
    output logic             busy
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid holds its payload until then, ready may change freely.

    localparam int CNT_W = $clog2(WIDTH);
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_LSR = 4'h8;
    localparam logic [3:0] OP_LSL = 4'h9;
    localparam logic [3:0] OP_ROR = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_LDA = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] result_q;
    logic             wb_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       flags_q;

    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             mul_s;
    logic             mul_last;

    logic [3:0]       cond;
    logic [3:0]       opcode;
    logic             s_bit;
    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   rot_amt;
    logic [WIDTH+15:0] imm_ext;
    logic [WIDTH-1:0] imm_val;
    logic             cond_pass;
    logic             accept;
    logic             start_mul;
    logic             unused_bits;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH:0]   lsr_ext;
    logic [WIDTH:0]   lsl_ext;
    logic [WIDTH-1:0] ror_res;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_exec;
    logic             alu_wb;
    logic [3:0]       alu_flags;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h1:    return z;
            4'h2:    return !z && (n == v);
            4'h3:    return n != v;
            4'h4:    return n == v;
            4'h5:    return z || (n != v);
            4'h6:    return cf && !z;
            4'h7:    return !cf;
            4'h8:    return cf;
            default: return 1'b1;
        endcase
    endfunction

    assign cond        = instruction[31:28];
    assign opcode      = instruction[27:24];
    assign s_bit       = instruction[23];
    assign shamt       = instruction[SHW+2:3];
    assign imm_ext     = {{WIDTH{1'b0}}, instruction[18:3]};
    assign imm_val     = imm_ext[WIDTH-1:0];
    assign unused_bits = ^instruction[22:19];

    assign cond_pass = cond_ok(cond, flags_q);
    assign accept    = in_valid && in_ready;
    assign start_mul = cond_pass && (opcode == OP_MUL);
    assign mul_last  = (state == ST_MUL) && (cnt == CNT_W'(WIDTH - 1));

    // Shift amounts past WIDTH are possible when WIDTH is not a power of two;
    // the extended vectors make those shift everything out cleanly.
    assign add_sum = {1'b0, op_a} + {1'b0, op_b};
    assign sub_sum = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH + 1)'(1);
    assign lsr_ext = {op_b, 1'b0} >> shamt;
    assign lsl_ext = {1'b0, op_b} << shamt;
    assign rot_amt = SHW'(32'(shamt) % WIDTH);
    assign ror_res = (op_b >> rot_amt) | (op_b << (WIDTH - int'(rot_amt)));

    assign acc_next = mul_b[0] ? (acc + mul_a) : acc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = start_mul ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                if (mul_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (accept)         state_next = start_mul ? ST_MUL : ST_DONE;
                else if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_MUL:  busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Single-cycle execution; a failed condition or undefined opcode is a NOP.
    always_comb begin
        alu_res  = '0;
        alu_c    = flags_q[1];
        alu_v    = flags_q[0];
        alu_exec = cond_pass;
        alu_wb   = 1'b1;
        case (opcode)
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
                if (opcode == OP_CMP) alu_wb = 1'b0;
            end
            OP_MUL: alu_res = '0;
            OP_OR:  alu_res = op_a | op_b;
            OP_AND: alu_res = op_a & op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_LDI, OP_LDA: alu_res = imm_val;
            OP_MOV: alu_res = op_b;
            OP_LSR: begin
                alu_res = lsr_ext[WIDTH:1];
                if (shamt != '0) alu_c = lsr_ext[0];
            end
            OP_LSL: begin
                alu_res = lsl_ext[WIDTH-1:0];
                if (shamt != '0) alu_c = lsl_ext[WIDTH];
            end
            OP_ROR: begin
                alu_res = ror_res;
                if (shamt != '0) alu_c = ror_res[MSB];
            end
            default: alu_exec = 1'b0;
        endcase
        if (!alu_exec) begin
            alu_res = '0;
            alu_wb  = 1'b0;
        end
        if (alu_exec && (s_bit || opcode == OP_CMP)) begin
            alu_flags = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
        end else begin
            alu_flags = flags_q;
        end
    end

    // Result, flags and multiplier datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            wb_q     <= 1'b0;
            tag_q    <= '0;
            flags_q  <= 4'b0000;
            mul_a    <= '0;
            mul_b    <= '0;
            acc      <= '0;
            cnt      <= '0;
            mul_s    <= 1'b0;
        end else if (accept) begin
            tag_q <= in_tag;
            if (start_mul) begin
                mul_a <= op_a;
                mul_b <= op_b;
                acc   <= '0;
                cnt   <= '0;
                mul_s <= s_bit;
            end else begin
                result_q <= alu_res;
                wb_q     <= alu_wb;
                flags_q  <= alu_flags;
            end
        end else if (state == ST_MUL) begin
            acc   <= acc_next;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            if (mul_last) begin
                cnt      <= '0;
                result_q <= acc_next;
                wb_q     <= 1'b1;
                if (mul_s) flags_q <= {acc_next[MSB], (acc_next == '0), flags_q[1:0]};
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign result  = result_q;
    assign wb      = wb_q;
    assign out_tag = tag_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: vector table through a result scoreboard, plus MUL timing,
// output stall, and reset-abort sequences at WIDTH=32 and WIDTH=16.
module tb_alu_mc;

    localparam int W   = 32;
    localparam int TW  = 5;
    localparam int SBW = W + 1 + TW + 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instruction;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          wb;
    logic [TW-1:0] out_tag;
    logic [3:0]    flags;
    logic          busy;

    logic          reset16;
    logic          s_in_valid;
    logic          s_in_ready;
    logic [31:0]   s_instruction;
    logic [15:0]   s_op_a;
    logic [15:0]   s_op_b;
    logic [TW-1:0] s_in_tag;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [15:0]   s_result;
    logic          s_wb;
    logic [TW-1:0] s_out_tag;
    logic [3:0]    s_flags;
    logic          s_busy;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .wb(wb),
        .out_tag(out_tag), .flags(flags), .busy(busy)
    );

    alu_mc #(.WIDTH(16), .TAG_W(TW)) dut16 (
        .clk(clk), .reset(reset16), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .instruction(s_instruction), .op_a(s_op_a), .op_b(s_op_b), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .wb(s_wb),
        .out_tag(s_out_tag), .flags(s_flags), .busy(s_busy)
    );

    typedef struct {
        logic [31:0]  ins;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] er;
        logic         ewb;
        logic [3:0]   ef;
    } vec_t;

    logic [SBW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op,
                                       input logic s, input logic [15:0] imm);
        return {c, op, s, 4'b0000, imm, 3'b000};
    endfunction

    // Drive one op and hold it until accepted; expected output is queued at accept.
    task automatic send(input logic [31:0] ins, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] er, input logic ewb,
                        input logic [3:0] ef, input bit push, output int waits);
        in_valid    = 1'b1;
        instruction = ins;
        op_a        = a;
        op_b        = b;
        in_tag      = tag;
        waits       = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waits);
        end else if (push) begin
            exp_q.push_back({er, ewb, tag, ef});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare each consumed result against the oldest expectation.
    always @(negedge clk) begin
        logic [SBW-1:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: result 0x%0h tag %0d with nothing expected", result, out_tag);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", result, e[SBW-1:10]);
                check("sb_wb", wb, e[9]);
                check("sb_tag", out_tag, e[8:4]);
                check("sb_flags", flags, e[3:0]);
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        vec_t vecs[19];
        int   waits;
        int   lat;
        int   busy_cnt;
        int   outs;
        logic rdy_seen;

        reset = 1'b1; reset16 = 1'b1;
        in_valid = 1'b0; instruction = '0; op_a = '0; op_b = '0; in_tag = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_instruction = '0; s_op_a = '0; s_op_b = '0; s_in_tag = '0;
        s_out_ready = 1'b1;

        //           cond  op    S     imm       a             b             result        wb    flags
        vecs[0]  = '{mk(4'h0, 4'h0, 1'b1, 16'h0),    32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 4'h9};
        vecs[1]  = '{mk(4'h0, 4'hB, 1'b0, 16'h0),    32'h5,        32'h5,        32'h0,        1'b0, 4'h6};
        vecs[2]  = '{mk(4'h1, 4'h7, 1'b0, 16'h0),    32'h0,        32'hAB,       32'hAB,       1'b1, 4'h6};
        vecs[3]  = '{mk(4'h3, 4'h0, 1'b1, 16'h0),    32'h1,        32'h2,        32'h0,        1'b0, 4'h6};
        vecs[4]  = '{mk(4'h0, 4'hA, 1'b1, 16'h1),    32'h0,        32'h80000001, 32'hC0000000, 1'b1, 4'hA};
        vecs[5]  = '{mk(4'h0, 4'h9, 1'b1, 16'h0),    32'h0,        32'h3,        32'h3,        1'b1, 4'h2};
        vecs[6]  = '{mk(4'h0, 4'h1, 1'b1, 16'h0),    32'h3,        32'h5,        32'hFFFFFFFE, 1'b1, 4'h8};
        vecs[7]  = '{mk(4'h7, 4'h3, 1'b1, 16'h0),    32'hF0,       32'h0F,       32'hFF,       1'b1, 4'h0};
        vecs[8]  = '{mk(4'h8, 4'h6, 1'b0, 16'h1234), 32'h0,        32'h0,        32'h0,        1'b0, 4'h0};
        vecs[9]  = '{mk(4'h0, 4'h4, 1'b1, 16'h0),    32'hF0,       32'h0F,       32'h0,        1'b1, 4'h4};
        vecs[10] = '{mk(4'h1, 4'h5, 1'b0, 16'h0),    32'hFF00,     32'h0FF0,     32'hF0F0,     1'b1, 4'h4};
        vecs[11] = '{mk(4'h0, 4'h8, 1'b1, 16'h2),    32'h0,        32'h80000003, 32'h20000000, 1'b1, 4'h2};
        vecs[12] = '{mk(4'h6, 4'hC, 1'b0, 16'hBEEF), 32'h0,        32'h0,        32'hBEEF,     1'b1, 4'h2};
        vecs[13] = '{mk(4'h0, 4'hE, 1'b1, 16'h0),    32'h1,        32'h1,        32'h0,        1'b0, 4'h2};
        vecs[14] = '{mk(4'h2, 4'h0, 1'b1, 16'h0),    32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 4'h6};
        vecs[15] = '{mk(4'h5, 4'h1, 1'b1, 16'h0),    32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 4'h3};
        vecs[16] = '{mk(4'h4, 4'h7, 1'b0, 16'h0),    32'h0,        32'h9,        32'h0,        1'b0, 4'h3};
        vecs[17] = '{mk(4'h9, 4'h9, 1'b1, 16'h1F),   32'h0,        32'h1,        32'h80000000, 1'b1, 4'h9};
        vecs[18] = '{mk(4'h0, 4'h0, 1'b1, 16'h0),    32'h80000000, 32'h80000000, 32'h0,        1'b1, 4'h7};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; reset16 = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_wb", wb, 0);
        check("rst_tag", out_tag, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst16_out_valid", s_out_valid, 0);
        check("rst16_flags", s_flags, 0);
        @(posedge clk);
        #1;

        // Back-to-back vectors; flag dependencies chain from one row to the next.
        for (int i = 0; i < 19; i++) begin
            send(vecs[i].ins, vecs[i].a, vecs[i].b, TW'(i), vecs[i].er, vecs[i].ewb,
                 vecs[i].ef, 1'b1, waits);
            if (i > 0) check("b2b_no_wait", waits, 0);
        end

        // MUL: 0xFFFF * 0x10001 with S=1, flags before are 0111.
        send(mk(4'h0, 4'h2, 1'b1, 16'h0), 32'hFFFF, 32'h10001, 5'd20, 32'hFFFFFFFF, 1'b1,
             4'hB, 1'b1, waits);
        lat = 0; busy_cnt = 0; rdy_seen = 1'b0;
        for (int i = 1; i <= W + 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i - 1;
                break;
            end
            busy_cnt += int'(busy);
            rdy_seen |= in_ready;
        end
        check("mul_latency", lat, W);
        check("mul_busy_cycles", busy_cnt, W);
        check("mul_in_ready_low", rdy_seen, 0);
        check("mul_busy_done", busy, 0);
        @(posedge clk);
        #1;

        // Stalled result: held stable with in_ready low until out_ready returns.
        out_ready = 1'b0;
        send(mk(4'h0, 4'h6, 1'b0, 16'h1234), 32'h0, 32'h0, 5'd7, 32'h1234, 1'b1, 4'hB,
             1'b1, waits);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_result", result, 32'h1234);
            check("stall_in_ready", in_ready, 0);
            check("stall_tag", out_tag, 7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(mk(4'h0, 4'h7, 1'b0, 16'h0), 32'h0, 32'h55, 5'd8, 32'h55, 1'b1, 4'hB, 1'b1, waits);
        check("release_same_cycle", waits, 0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset in the 10th MUL cycle aborts the multiply; nothing may come out.
        send(mk(4'h0, 4'h2, 1'b0, 16'h0), 32'h3, 32'h5, 5'd9, 32'hF, 1'b1, 4'hB, 1'b1, waits);
        repeat (9) @(posedge clk);
        #1;
        check("mid_mul_busy", busy, 1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_wb", wb, 0);
        check("abort_tag", out_tag, 0);
        check("abort_flags", flags, 0);
        check("abort_busy", busy, 0);
        outs = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            outs += int'(out_valid);
        end
        check("abort_no_output", outs, 0);

        // WIDTH=16: full MUL, then reset-abort of a second one.
        @(posedge clk);
        #1;
        s_instruction = mk(4'h0, 4'h2, 1'b1, 16'h0);
        s_op_a = 16'h00FF; s_op_b = 16'h0101; s_in_tag = 5'd3; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 0; busy_cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (s_out_valid) begin
                lat = i - 1;
                break;
            end
            busy_cnt += int'(s_busy);
        end
        check("w16_mul_latency", lat, 16);
        check("w16_mul_busy_cycles", busy_cnt, 16);
        check("w16_mul_result", s_result, 16'hFFFF);
        check("w16_mul_flags", s_flags, 4'h8);
        check("w16_mul_tag", s_out_tag, 3);
        @(posedge clk);
        #1;
        s_op_a = 16'h0003; s_op_b = 16'h0007; s_in_tag = 5'd4; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset16 = 1'b1;
        @(posedge clk);
        #1;
        reset16 = 1'b0;
        @(negedge clk);
        check("w16_abort_out_valid", s_out_valid, 0);
        check("w16_abort_result", s_result, 0);
        check("w16_abort_flags", s_flags, 0);
        check("w16_abort_busy", s_busy, 0);
        check("w16_abort_in_ready", s_in_ready, 1);
        check("w16_abort_wb", s_wb, 0);
        outs = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            outs += int'(s_out_valid);
        end
        check("w16_abort_no_output", outs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
